// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory between
// the CPU load/store port (0) and the loader/debug DMA port (1).

module data_mem_arbiter_port #(
   parameter int DATA_W = 32
) (
   input  logic              resp_valid,
   input  logic              resp_sel,
   input  logic              resp_read,
   input  logic              resp_err,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              err
);
   assign rvalid = resp_valid && resp_sel && resp_read && !resp_err;
   assign rdata  = rvalid ? mem_data_out : '0;
   assign err    = resp_valid && resp_sel && resp_err;
endmodule

module data_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_err,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_data_out
);
   localparam int NP = 2;

   logic [NP-1:0]             req, we, gnt, rvalid, err, resp_sel;
   logic [NP-1:0][ADDR_W-1:0] addr;
   logic [NP-1:0][DATA_W-1:0] wdata, rdata;

   logic              rr_last, resp_valid_q, resp_port_q, resp_read_q, resp_err_q;
   logic              any_gnt, win, sel_we, in_range;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign req   = {p1_req, p0_req};
   assign we    = {p1_we, p0_we};
   assign addr  = {p1_addr, p0_addr};
   assign wdata = {p1_wdata, p0_wdata};

   // On contention the port that did not win last time goes first.
   always_comb begin
      gnt = '0;
      if (rst_n) begin
         if (req[0] && (!req[1] || rr_last)) gnt[0] = 1'b1;
         else if (req[1])                    gnt[1] = 1'b1;
      end
   end

   assign any_gnt   = |gnt;
   assign win       = gnt[1];
   assign sel_we    = we[win];
   assign sel_addr  = addr[win];
   assign sel_wdata = wdata[win];
   assign in_range  = sel_addr < ADDR_W'(DEPTH);

   // Out-of-range accesses park the memory on address 0 with writes blocked.
   assign mem_addr    = (any_gnt && in_range) ? sel_addr : '0;
   assign mem_data_in = any_gnt ? sel_wdata : '0;
   assign mem_we      = any_gnt && sel_we && in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_port_q  <= 1'b0;
         resp_read_q  <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= any_gnt;
         if (any_gnt) begin
            rr_last     <= win;
            resp_port_q <= win;
            resp_read_q <= !sel_we;
            resp_err_q  <= !in_range;
         end
      end
   end

   assign resp_sel = {resp_port_q, !resp_port_q};

   for (genvar i = 0; i < NP; i++) begin : g_port
      data_mem_arbiter_port #(.DATA_W(DATA_W)) u_port (
         .resp_valid   (resp_valid_q),
         .resp_sel     (resp_sel[i]),
         .resp_read    (resp_read_q),
         .resp_err     (resp_err_q),
         .mem_data_out (mem_data_out),
         .rvalid       (rvalid[i]),
         .rdata        (rdata[i]),
         .err          (err[i])
      );
   end

   assign p0_gnt    = gnt[0];
   assign p1_gnt    = gnt[1];
   assign p0_rvalid = rvalid[0];
   assign p1_rvalid = rvalid[1];
   assign p0_rdata  = rdata[0];
   assign p1_rdata  = rdata[1];
   assign p0_err    = err[0];
   assign p1_err    = err[1];
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: behavioural memory plus a transaction-level
// reference model, directed scenarios followed by random two-port traffic.

module tb_data_mem_arbiter;
   localparam int AW = 32, DW = 32, DEPTH = 1024;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
   logic [AW-1:0] p0_addr = 0, p1_addr = 0;
   logic [DW-1:0] p0_wdata = 0, p1_wdata = 0;
   logic          p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, mem_we;
   logic [DW-1:0] p0_rdata, p1_rdata, mem_data_in;
   logic [DW-1:0] mem_data_out = 0;
   logic [AW-1:0] mem_addr;

   data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
      .mem_data_out(mem_data_out)
   );

   // Single-port memory with registered read-before-write output.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_data_in;
      mem_data_out <= mem[mem_addr[9:0]];
   end

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      bit          v;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } rq_t;

   rq_t         rq [2];
   logic [31:0] ref_mem [DEPTH];
   int          last_win;
   bit          exp_rv [2], exp_err [2];
   logic [31:0] exp_rd [2];
   bit          auto_gen = 0;

   function automatic rq_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      rq_t r;
      r.v = 1; r.we = we; r.addr = addr; r.wdata = wdata;
      return r;
   endfunction

   function automatic rq_t rand_req();
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = $urandom_range(0, 15);
      else if (sel == 7) a = 32'd1023;
      else if (sel == 8) a = 32'd1024 + $urandom_range(0, 3);
      else               a = 32'hFFFF_FFFF - $urandom_range(0, 3);
      return mk(1'($urandom_range(0, 1)), a, $urandom);
   endfunction

   task automatic drive();
      p0_req = rq[0].v; p0_we = rq[0].we; p0_addr = rq[0].addr; p0_wdata = rq[0].wdata;
      p1_req = rq[1].v; p1_we = rq[1].we; p1_addr = rq[1].addr; p1_wdata = rq[1].wdata;
   endtask

   task automatic model_clear();
      for (int p = 0; p < 2; p++) begin
         rq[p] = '{0, 0, 0, 0};
         exp_rv[p] = 0; exp_err[p] = 0; exp_rd[p] = 0;
      end
      last_win = 1;
   endtask

   task automatic chk_resp();
      chk("p0_rvalid", 32'(p0_rvalid), 32'(exp_rv[0]));
      chk("p0_rdata",  p0_rdata,       exp_rd[0]);
      chk("p0_err",    32'(p0_err),    32'(exp_err[0]));
      chk("p1_rvalid", 32'(p1_rvalid), 32'(exp_rv[1]));
      chk("p1_rdata",  p1_rdata,       exp_rd[1]);
      chk("p1_err",    32'(p1_err),    32'(exp_err[1]));
   endtask

   // One clock: drive pending requests, check at the falling edge, advance model.
   task automatic cycle();
      int g;
      bit inr;
      drive();
      @(negedge clk);
      if (rq[0].v && rq[1].v) g = 1 - last_win;
      else if (rq[0].v)       g = 0;
      else if (rq[1].v)       g = 1;
      else                    g = -1;
      inr = (g >= 0) && (rq[g].addr < DEPTH);
      chk("p0_gnt", 32'(p0_gnt), 32'(g == 0));
      chk("p1_gnt", 32'(p1_gnt), 32'(g == 1));
      chk("mem_we", 32'(mem_we), 32'(inr && rq[g].we));
      chk("mem_addr", mem_addr, inr ? rq[g].addr : 32'd0);
      chk("mem_data_in", mem_data_in, (g >= 0) ? rq[g].wdata : 32'd0);
      chk_resp();
      for (int p = 0; p < 2; p++) begin
         exp_rv[p] = 0; exp_err[p] = 0; exp_rd[p] = 0;
      end
      if (g >= 0) begin
         if (!inr) exp_err[g] = 1;
         else if (!rq[g].we) begin
            exp_rv[g] = 1;
            exp_rd[g] = ref_mem[rq[g].addr[9:0]];
         end else ref_mem[rq[g].addr[9:0]] = rq[g].wdata;
         last_win = g;
         rq[g].v = 0;
      end
      @(posedge clk); #1;
      if (auto_gen)
         for (int p = 0; p < 2; p++)
            if (!rq[p].v && $urandom_range(0, 3) != 0) rq[p] = rand_req();
   endtask

   task automatic do_reset();
      model_clear();
      drive();
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_resp();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
         ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
      end
      model_clear();

      // Reset state, with a write request held high while in reset.
      p0_req = 1; p0_we = 1; p0_addr = 5; p0_wdata = 32'h1111_2222;
      #3;
      chk("rst_p0_gnt", 32'(p0_gnt), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data_in", mem_data_in, 0);
      chk_resp();
      do_reset();

      // Write then read back on port 0.
      rq[0] = mk(1, 5, 32'hDEAD_BEEF); cycle();
      rq[0] = mk(0, 5, 32'h0);         cycle();
      cycle();

      // Continuous contention from reset: strict alternation.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (!rq[0].v) rq[0] = mk(0, 32'(i), 0);
         if (!rq[1].v) rq[1] = mk(0, 32'(16 + i), 0);
         cycle();
      end
      rq[0].v = 0; rq[1].v = 0;
      cycle();

      // Port 1 alone, back-to-back reads of 0..7.
      for (int i = 0; i < 8; i++) begin
         rq[1] = mk(0, 32'(i), 32'(i));
         cycle();
      end
      cycle();

      // Boundary addresses.
      rq[0] = mk(1, 1023, 32'hCAFE_F00D); cycle();
      rq[0] = mk(1, 1024, 32'hBAD0_0001); cycle();
      rq[0] = mk(0, 32'hFFFF_FFFF, 0);    cycle();
      rq[0] = mk(0, 1023, 0);             cycle();
      rq[0] = mk(0, 0, 0);                cycle();
      cycle();

      // Reset asserted half a cycle after a read grant.
      do_reset();
      rq[0] = mk(0, 5, 0);
      drive();
      @(negedge clk);
      chk("mid_p0_gnt_before", 32'(p0_gnt), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_p0_gnt_in_rst", 32'(p0_gnt), 0);
      chk("mid_mem_we_in_rst", 32'(mem_we), 0);
      @(posedge clk); #1;
      model_clear();
      chk_resp();
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rq[0] = mk(0, 1, 0); rq[1] = mk(0, 2, 0);
      cycle(); cycle(); cycle();

      // Same-cycle write (p0) and read (p1) of one address.
      do_reset();
      rq[0] = mk(1, 9, 32'h0000_1234);
      rq[1] = mk(0, 9, 0);
      cycle(); cycle(); cycle();

      // Random two-port traffic.
      auto_gen = 1;
      for (int i = 0; i < 400; i++) cycle();
      auto_gen = 0;
      rq[0].v = 0; rq[1].v = 0;
      cycle(); cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter that shares the single-port, synchronous-read data memory (1024 × 32-bit words, word-indexed, one-cycle registered read) between port 0 (CPU load/store unit) and port 1 (loader/debug DMA). It grants at most one access per cycle using round-robin, drives the memory's address, write-data and write-enable inputs, and routes the registered read data back to the winning port one cycle later. It rejects out-of-range addresses with an error response and never touches memory for them.

## Interface
Parameters:
- ADDR_W, 32, width of port and memory addresses (word index, not byte address)
- DATA_W, 32, data width
- DEPTH, 1024, number of memory words; an address ≥ DEPTH is out of range

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- p0_req / p1_req  in  1  access request; held high until granted
- p0_we / p1_we  in  1  1 = write, 0 = read; valid while req is high
- p0_addr / p1_addr  in  ADDR_W  word address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_gnt / p1_gnt  out  1  combinational grant; access is accepted in the cycle where req && gnt
- p0_rvalid / p1_rvalid  out  1  read response valid, one cycle after grant
- p0_rdata / p1_rdata  out  DATA_W  read data; 0 when rvalid is low
- p0_err / p1_err  out  1  one-cycle pulse one cycle after grant of an out-of-range access
- mem_addr  out  ADDR_W  to memory data_address
- mem_data_in  out  DATA_W  to memory data_in
- mem_we  out  1  to memory we
- mem_data_out  in  DATA_W  from memory data_out (registered in memory)

## Operation
- State: rr_last (last winning port), resp_valid_q, resp_port_q, resp_read_q, resp_err_q.
- Arbitration, combinational each cycle:
  - Only one req high: that port is granted.
  - Both high: the port ≠ rr_last is granted.
  - Neither high: no grant.
  - At most one gnt is high per cycle. Both gnt are forced low while rst_n is low.
- rr_last updates to the winner on every grant. Reset value is 1, so port 0 wins the first contention.
- Memory drive:
  - mem_addr and mem_data_in come from the granted port. With no grant, they are 0.
  - mem_we = grant && we && (addr < DEPTH).
  - Out-of-range accesses pass addr 0 with mem_we 0, so memory is neither written nor meaningfully read.
- Response stage, registered on the grant edge:
  - resp_valid_q = any grant; resp_port_q = winner; resp_read_q = !we; resp_err_q = addr ≥ DEPTH.
- Next cycle, for the port equal to resp_port_q:
  - rvalid = resp_valid_q && resp_read_q && !resp_err_q.
  - rdata = mem_data_out when rvalid, else 0.
  - err = resp_valid_q && resp_err_q. This covers both reads and writes.
  - The other port's rvalid, err and rdata are 0.
- Writes produce no rvalid. A write is complete once it is granted.
- There is no backpressure on responses. A requester must accept rvalid and err in the cycle they appear.

## Timing
- Throughput: one grant per cycle, back-to-back, with either port or alternating ports.
- Read latency: grant in cycle N, rvalid and rdata in cycle N+1.
- The memory returns the pre-write value on its write cycle. A read granted in the cycle after a write to the same address returns the new data.
- Reset values: rr_last = 1; resp_valid_q, resp_read_q, resp_err_q, resp_port_q = 0; all gnt, rvalid, err, rdata = 0; mem_we = 0; mem_addr and mem_data_in = 0.
- Reset asserted mid-operation:
  - A pending response is dropped, so no rvalid or err follows.
  - mem_we drops low immediately (asynchronous).
  - A write already sampled by memory on the same edge is not undone.
- Boundary addresses:
  - addr = DEPTH−1 is in range.
  - addr = DEPTH and any higher value, including the top bits of ADDR_W, are out of range.
- Fairness: under continuous contention, grants strictly alternate. A port waits at most 1 cycle.

## Test plan
- Reset, then p0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> mem_we=1 for one cycle; p0_rvalid=1 with p0_rdata=0xDEADBEEF one cycle after the read grant; p1 outputs stay 0.
- p0 and p1 both request reads continuously from reset -> grants go p0, p1, p0, p1. Each rvalid lands on the correct port one cycle after its grant, and rdata matches that port's address.
- p1 alone issues reads every cycle to addresses 0..7 -> p1_gnt stays high 8 cycles; 8 consecutive p1_rvalid pulses return the data in address order.
- p0 writes to addr 1023, then addr 1024, then reads addr 0xFFFFFFFF -> first write commits. Second: mem_we=0 and p0_err pulses next cycle. Read: p0_err=1, p0_rvalid=0, p0_rdata=0.
- p0 read granted in cycle N, rst_n pulled low in cycle N+0.5 -> no p0_rvalid in cycle N+1; all outputs 0. After release, the first contended cycle grants p0.
- p0 writes 0x1234 to addr 9 while p1 requests a read of addr 9 in the same cycle -> p0 granted first, p1 the next cycle; p1_rdata=0x1234.
